// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared hazard-control types and constants
// Provides the controller state enum, the register-index width and the x0 index.
package pipe_ctrl_pkg;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;
    typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter
// Ports: clk, reset (async, active-high), en (count this cycle), count (holds at all-ones).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else if (en && count != '1) count <= count + WIDTH'(1);
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (load-use stall, redirect flush, multicycle wait)
// Inputs: ID operand info, EX load/redirect info, multicycle done.
// Outputs: PC/IF-ID enables, flush/bubble, redirect select/target, mc_start,
// sticky mc_timeout, saturating stall_cycles/flush_count.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 id_mc_op,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_redirect,
    input  logic [XLEN-1:0]      ex_target,
    input  logic                 mc_done,
    output logic                 pc_we,
    output logic                 ifid_we,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic                 pc_sel_redirect,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 mc_start,
    output logic                 mc_timeout,
    output logic [31:0]          stall_cycles,
    output logic [15:0]          flush_count
);
    localparam int CW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] to_cnt;
    logic          load_use, timeout_hit, mc_go;

    assign load_use = id_valid && ex_mem_read && ex_rd != ZERO_REG &&
                      ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    assign mc_go = !ex_redirect && !load_use && id_valid && id_mc_op;
    // Last permitted wait cycle: release the stall now and flag the abort.
    assign timeout_hit = state == MC_WAIT && !mc_done && to_cnt == CW'(MC_TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else state <= state_nxt;
    end

    // Counter is held at zero throughout RUN so every wait starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt     <= '0;
            mc_timeout <= 1'b0;
        end else begin
            if (state == RUN) to_cnt <= '0;
            else if (!mc_done) to_cnt <= to_cnt + CW'(1);
            if (timeout_hit) mc_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN) state_nxt = mc_go ? MC_WAIT : RUN;
        else state_nxt = (mc_done || timeout_hit) ? RUN : MC_WAIT;
    end

    always_comb begin
        pc_we           = 1'b0;
        ifid_we         = 1'b0;
        ifid_flush      = 1'b0;
        idex_bubble     = 1'b0;
        pc_sel_redirect = 1'b0;
        redirect_pc     = '0;
        mc_start        = 1'b0;
        if (reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state == RUN) begin
            if (ex_redirect) begin
                pc_we           = 1'b1;
                ifid_we         = 1'b1;
                ifid_flush      = 1'b1;
                idex_bubble     = 1'b1;
                pc_sel_redirect = 1'b1;
                redirect_pc     = ex_target;
            end else if (load_use || mc_go) begin
                idex_bubble = 1'b1;
                mc_start    = mc_go;
            end else begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
            end
        end else begin
            pc_we       = mc_done || timeout_hit;
            ifid_we     = mc_done || timeout_hit;
            idex_bubble = !(mc_done || timeout_hit);
        end
    end

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (!pc_we && !reset),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_flush && !reset),
        .count (flush_count)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int XLEN = 32;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_mc_op = 0;
    logic [4:0]      id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic            ex_mem_read = 0, ex_redirect = 0, mc_done = 0;
    logic [XLEN-1:0] ex_target = 0;
    logic            pc_we, ifid_we, ifid_flush, idex_bubble, pc_sel_redirect, mc_start, mc_timeout;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     stall_cycles;
    logic [15:0]     flush_count;

    hazard_ctrl #(.XLEN(XLEN), .MC_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_mc_op(id_mc_op),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .mc_done(mc_done), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pc_sel_redirect(pc_sel_redirect),
        .redirect_pc(redirect_pc), .mc_start(mc_start), .mc_timeout(mc_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    logic [37:0] exp_q[$];
    bit m_wait, m_to;
    int m_cnt, m_stall, m_flush;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] ctrl_vec();
        return {pc_we, ifid_we, ifid_flush, idex_bubble, pc_sel_redirect, mc_start, redirect_pc};
    endfunction

    task automatic check_cnt(input string tag);
        check({tag, "_stall"}, 64'(stall_cycles), 64'(m_stall));
        check({tag, "_flush"}, 64'(flush_count), 64'(m_flush));
        check({tag, "_to"}, 64'(mc_timeout), 64'(m_to));
    endtask

    task automatic step(input string tag, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic mc, input logic [4:0] rd,
                        input logic ld, input logic rdr, input logic [31:0] tgt, input logic done);
        logic lu, rel;
        logic [37:0] e;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_mc_op = mc; ex_rd = rd; ex_mem_read = ld; ex_redirect = rdr; ex_target = tgt; mc_done = done;
        lu = v && ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        rel = done || m_cnt == TO - 1;
        if (!m_wait) begin
            if (rdr) e = {6'b111110, tgt};
            else if (lu) e = {6'b000100, 32'h0};
            else if (v && mc) e = {6'b000101, 32'h0};
            else e = {6'b110000, 32'h0};
        end else begin
            e = rel ? {6'b110000, 32'h0} : {6'b000100, 32'h0};
        end
        exp_q.push_back(e);
        @(negedge clk);
        check(tag, 64'(ctrl_vec()), 64'(exp_q.pop_front()));
        if (!e[37]) m_stall++;
        if (e[35]) m_flush++;
        if (!m_wait) begin
            if (!rdr && !lu && v && mc) begin m_wait = 1; m_cnt = 0; end
        end else if (done) m_wait = 0;
        else if (m_cnt == TO - 1) begin m_wait = 0; m_to = 1; end
        else m_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        ex_redirect = 1; ex_target = 32'hDEAD_BEEF; id_valid = 1; id_mc_op = 1;
        #1;
        check({tag, "_ctrl"}, 64'(ctrl_vec()), 64'({6'b001100, 32'h0}));
        m_wait = 0; m_cnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
        check_cnt(tag);
        @(posedge clk);
        #1;
        check_cnt({tag, "_held"});
        reset = 1'b0;
        ex_redirect = 0; ex_target = 0; id_valid = 0; id_mc_op = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset("rst0");
        step("lu_rs1", 1, 5, 0, 1, 0, 0, 5, 1, 0, 32'h0, 0);
        check("stall_one", 64'(stall_cycles), 64'd1);
        step("after_lu", 1, 5, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0);
        step("lu_rs2", 1, 0, 7, 0, 1, 0, 7, 1, 0, 32'h0, 0);
        step("rs1_unused", 1, 7, 0, 0, 1, 0, 7, 1, 0, 32'h0, 0);
        step("rd_zero", 1, 0, 0, 1, 1, 0, 0, 1, 0, 32'h0, 0);
        step("done_in_run", 1, 3, 4, 1, 1, 0, 9, 0, 0, 32'h0, 1);
        check("stall_two", 64'(stall_cycles), 64'd2);
        check_cnt("lu");

        do_reset("rst1");
        step("redir_lu", 1, 5, 0, 1, 0, 1, 5, 1, 1, 32'h0000_0100, 0);
        check("flush_one", 64'(flush_count), 64'd1);
        check("stall_zero", 64'(stall_cycles), 64'd0);
        step("redir_mc", 1, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0200, 0);
        idle("after_redir");
        check_cnt("redir");

        do_reset("rst2");
        step("mc_start", 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) step("mc_wait", 1, 5, 0, 1, 0, 1, 5, 1, 1, 32'h0000_0300, 0);
        step("mc_done", 1, 5, 0, 1, 0, 0, 0, 0, 0, 32'h0, 1);
        check("stall_six", 64'(stall_cycles), 64'd6);
        idle("mc_run");
        check_cnt("mc");

        do_reset("rst3");
        step("to_start", 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < TO; i++) step("to_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        check("to_flag", 64'(mc_timeout), 64'd1);
        check("to_stall", 64'(stall_cycles), 64'd8);
        for (int i = 0; i < 3; i++) idle("to_sticky");
        check_cnt("to");

        step("abort_start", 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        idle("abort_wait");
        idle("abort_wait");
        do_reset("rst_mid");
        idle("post_abort");
        check_cnt("abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter XLEN, 32, address/target width.
REQ-002 Parameter MC_TIMEOUT, 64, max MC_WAIT cycles before abort (>=2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 id_rs1, id_rs2  in  5 each  ID source register indices.
REQ-007 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-008 id_mc_op  in  1  ID instruction needs the multicycle unit (mul/div).
REQ-009 ex_rd  in  5  EX destination index; ex_mem_read  in  1  EX instruction is a load.
REQ-010 ex_redirect  in  1  EX resolved taken branch/jump; ex_target  in  XLEN  its target.
REQ-011 mc_done  in  1  multicycle unit result ready (single-cycle pulse).
REQ-012 pc_we, ifid_we  out  1 each  PC and IF/ID register write enables.
REQ-013 ifid_flush  out  1  load IF/ID with zero instruction/PC next edge.
REQ-014 idex_bubble  out  1  insert bubble into ID/EX next edge.
REQ-015 pc_sel_redirect  out  1  select redirect_pc as next PC; redirect_pc  out  XLEN.
REQ-016 mc_start  out  1  one-cycle start pulse to multicycle unit.
REQ-017 mc_timeout  out  1  sticky error flag.
REQ-018 stall_cycles  out  32 and flush_count  out  16  saturating perf counters.

Function
REQ-019 load_use = id_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-020 FSM states RUN, MC_WAIT; controls combinational from state and inputs (Mealy), zero added latency.
REQ-021 RUN priority 1, ex_redirect: pc_we=1, ifid_we=1, pc_sel_redirect=1, redirect_pc=ex_target, ifid_flush=1, idex_bubble=1, mc_start=0, stay RUN.
REQ-022 RUN priority 2, load_use: pc_we=0, ifid_we=0, idex_bubble=1 for exactly that cycle.
REQ-023 RUN priority 3, id_valid & id_mc_op: mc_start=1, pc_we=0, ifid_we=0, idex_bubble=1, next MC_WAIT, timeout counter cleared.
REQ-024 RUN default: pc_we=1, ifid_we=1, all other controls 0.
REQ-025 MC_WAIT, mc_done=0: pc_we=0, ifid_we=0, idex_bubble=1; timeout counter +1.
REQ-026 MC_WAIT, mc_done=1: pc_we=1, ifid_we=1, idex_bubble=0, next RUN (mc op advances with result).
REQ-027 MC_WAIT, counter reaches MC_TIMEOUT-1 without mc_done: set mc_timeout, behave as REQ-026, next RUN.
REQ-028 MC_WAIT ignores ex_redirect, id_mc_op, load_use (EX holds a bubble).
REQ-029 redirect with load_use or id_mc_op same cycle: redirect only, no mc_start, no stall.
REQ-030 mc_done in RUN ignored.
REQ-031 stall_cycles +1 each cycle pc_we=0 outside reset; flush_count +1 each cycle ifid_flush=1; both hold at all-ones.
REQ-032 ifid_flush and ifid_we never assert a stall simultaneously; pc_sel_redirect implies pc_we.

Reset
REQ-033 reset asserted: state=RUN, timeout counter=0, mc_timeout=0, stall_cycles=0, flush_count=0 immediately, independent of clk.
REQ-034 While reset: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pc_sel_redirect=0, redirect_pc=0, mc_start=0.
REQ-035 reset during MC_WAIT aborts the wait; first cycle after release is RUN.

Structure
REQ-036 Shared package pipe_ctrl_pkg: state enum (RUN, MC_WAIT), REG_IDX_W=5, zero-register constant.
REQ-037 One sub-module sat_counter (parameter WIDTH) instantiated for both perf counters; rest inline.

Verification
REQ-038 Load x5 in EX (ex_rd=5, ex_mem_read=1), ID reads rs1=5 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1; stall_cycles=1.
REQ-039 Same with ex_rd=0 -> no stall, pc_we=1.
REQ-040 ex_redirect=1, ex_target=0x0000_0100, concurrent load_use -> pc_sel_redirect=1, redirect_pc=0x100, ifid_flush=1, no stall; flush_count=1.
REQ-041 id_mc_op=1, mc_done after 5 cycles -> mc_start pulse 1 cycle, 5 stall cycles then release, state RUN; stall_cycles=6.
REQ-042 id_mc_op=1, no mc_done, MC_TIMEOUT=8 -> release at 8th MC_WAIT cycle, mc_timeout=1 sticky until reset.
REQ-043 reset asserted mid-MC_WAIT, off-edge -> outputs per REQ-034 immediately; counters 0; RUN after release.
